shift_accumulator: RTL
======================

Name: shift_accumulator

Overview:
- Accumulator/scaler stage directly downstream of the 40-bit add/sub unit in the MSDAP FIR datapath.
- Registers the adder's sum each term cycle and feeds the running value back as the adder's b operand.
- Applies the per-group arithmetic right shift of the power-of-two coefficient algorithm: y = (...((G0>>1 + G1)>>1 + ...) + G15)>>1.
- After NUM_GROUPS groups, publishes the finished sample with a one-cycle done pulse to the output serializer.

Parameters:
- WIDTH, 40, datapath width; must match the adder.
- NUM_GROUPS, 16, number of u-groups (shift events) per output sample.
- CNT_W, 4, group counter width; must satisfy 2^CNT_W >= NUM_GROUPS.

Ports:
- Sclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new output sample: clear the accumulator and the group count.
- term_valid  input  1  sum holds a valid term result this cycle; capture it.
- group_end  input  1  the current u-group ends this cycle; apply the shift after any capture.
- sum  input  WIDTH  two's-complement result from the adder.
- acc_out  output  WIDTH  current accumulator value; drives the adder's b operand.
- y_out  output  WIDTH  last completed output sample; held until the next completion.
- done  output  1  one-cycle pulse when y_out updates.
- busy  output  1  high while in the ACCUM state.
- group_cnt  output  CNT_W  index of the current group (0..NUM_GROUPS-1).

Behaviour:
- Reset is synchronous and active-high: while reset is sampled high at a Sclk edge, acc_out=0, y_out=0, done=0, busy=0, group_cnt=0, state=IDLE. Reset overrides all other inputs, including mid-sample.
- FSM states: IDLE and ACCUM. busy = (state==ACCUM), decoded from the registered state.
- IDLE:
  - start=1 -> acc<=0, group_cnt<=0, go to ACCUM.
  - term_valid and group_end are ignored.
- ACCUM, evaluated in priority order:
  - start=1 -> abort the sample: acc<=0, group_cnt<=0, stay in ACCUM. No done pulse; y_out is unchanged.
  - Otherwise, compute v = term_valid ? sum : acc.
  - If group_end=0: acc<=v.
  - If group_end=1: acc<=v>>>1, an arithmetic shift with sign bit replicated. An empty group (group_end without term_valid) therefore shifts the held value.
  - If group_end=1 and group_cnt<NUM_GROUPS-1: group_cnt<=group_cnt+1.
  - If group_end=1 and group_cnt==NUM_GROUPS-1 (final group): y_out<=final shifted value, done<=1, acc<=0, group_cnt<=0, go to IDLE. All of these update at the same edge.
- done is registered, high for exactly one cycle, and 0 in every other cycle.
- No internal saturation. sum wraps modulo 2^WIDTH in the adder; this block passes it through unchanged.
- Latency: y_out and done become valid at the edge that samples the final group_end.
- Simultaneous term_valid and group_end means capture then shift in a single edge.
- acc_out is the register output. The adder path is combinational, so sum is always consistent with acc_out in the same cycle.

Optional Feature:
- Macro: SHIFT_ACC_ROUND_EN.
- Defined: the final-group shift rounds half-up. y_out <= (v>>>1) + v[0]. The accumulator shifts on non-final groups still truncate.
- Undefined: every shift truncates, including the final one (y_out <= v>>>1).
- The rounding add cannot overflow, since v>>>1 is at most 2^(WIDTH-2)-1 for positive v.

Test Plan:
- Reset mid-sample: start, 5 group_ends, then reset=1 for one cycle -> next cycle acc_out=0, group_cnt=0, busy=0, done=0, y_out=0.
- Single-term scaling: start; the bench adder model drives sum=acc_out+0x00_0001_0000 with term_valid=1 and group_end=1 for group 0, then 15 empty group_ends -> done pulses at the 16th, y_out=0x00_0000_0001, busy falls the same edge.
- Negative sign extension: 15 empty group_ends, then term_valid=1 with sum=0xFF_FFFF_FFFE and group_end=1 -> y_out=0xFF_FFFF_FFFF in both builds.
- Rounding: term sum=3 in the final group only -> y_out=1 with SHIFT_ACC_ROUND_EN undefined, y_out=2 with it defined.
- Multi-term group: in group 0, three term_valid cycles adding 10, 20 and -5 via the adder model, the last with group_end -> acc_out=12 after the shift; the remaining empty groups give y_out=0.
- Abort and restart: start at group_cnt=7 -> acc_out=0, group_cnt=0, busy stays 1, no done; done occurs only after 16 further group_ends. term_valid and group_end pulses while in IDLE leave acc_out=0.

Source files
------------

// File: rtl/shift_accumulator_if.sv
// shift_accumulator_if: adder-facing control/data bundle between the FIR sequencer and the shift accumulator
interface shift_accumulator_if #(
   parameter int WIDTH = 40,
   parameter int CNT_W = 4
);
   logic             start;
   logic             term_valid;
   logic             group_end;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] acc_out;
   logic [WIDTH-1:0] y_out;
   logic             done;
   logic             busy;
   logic [CNT_W-1:0] group_cnt;
   modport master (
      output start, term_valid, group_end, sum,
      input  acc_out, y_out, done, busy, group_cnt
   );
   modport slave (
      input  start, term_valid, group_end, sum,
      output acc_out, y_out, done, busy, group_cnt
   );
endinterface

// File: rtl/shift_accumulator.sv
// shift_accumulator: MSDAP per-group accumulate and arithmetic-shift stage; SHIFT_ACC_ROUND_EN rounds the final shift half-up
module shift_accumulator #(
   parameter int WIDTH      = 40,
   parameter int NUM_GROUPS = 16,
   parameter int CNT_W      = 4
) (
   input logic                Sclk,
   input logic                reset,
   shift_accumulator_if.slave bus
);
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_GROUPS - 1);
   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n, y, y_n, v, sh, y_fin;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             done_q, done_n;
   always_comb begin
      v = bus.term_valid ? bus.sum : acc;
      sh = WIDTH'($signed(v) >>> 1);
`ifdef SHIFT_ACC_ROUND_EN
      y_fin = sh + WIDTH'(v[0]);
`else
      y_fin = sh;
`endif
   end
   always_comb begin
      state_n = state;
      acc_n = acc;
      y_n = y;
      cnt_n = cnt;
      done_n = 1'b0;
      if (state == IDLE) begin
         if (bus.start) begin
            acc_n = '0;
            cnt_n = '0;
            state_n = ACCUM;
         end
      end else if (bus.start) begin
         acc_n = '0;
         cnt_n = '0;
      end else if (!bus.group_end) begin
         acc_n = v;
      end else if (cnt == LAST) begin
         y_n = y_fin;
         done_n = 1'b1;
         acc_n = '0;
         cnt_n = '0;
         state_n = IDLE;
      end else begin
         acc_n = sh;
         cnt_n = cnt + CNT_W'(1);
      end
   end
   always_ff @(posedge Sclk) begin
      if (reset) begin
         state <= IDLE;
         acc <= '0;
         y <= '0;
         cnt <= '0;
         done_q <= 1'b0;
      end else begin
         state <= state_n;
         acc <= acc_n;
         y <= y_n;
         cnt <= cnt_n;
         done_q <= done_n;
      end
   end
   assign bus.acc_out = acc;
   assign bus.y_out = y;
   assign bus.done = done_q;
   assign bus.busy = (state == ACCUM);
   assign bus.group_cnt = cnt;
endmodule
